pipeline_event_monitor: RTL
===========================

Name: pipeline_event_monitor

Overview:
- Hardware run-control and performance monitor attached directly downstream of the pipelined CPU core.
- Consumes the core's start, load-use stall, branch flush and PC signals.
- Counts cycles, stall cycles and flush cycles, and asserts a halt request after a programmed cycle budget.
- Provides a valid/ready snapshot port so a host or bench can read a coherent set of counters.

Parameters:
- CNT_W, 32, width of every counter and snapshot field.
- MAX_CYCLES, 20, cycle budget; halt is requested after this many counted cycles.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  core start; counting is enabled only while high.
- stall_i  in  1  load-use stall indication from the hazard unit.
- flush_i  in  1  branch flush indication from the branch unit.
- pc_i  in  32  current PC register value.
- clear_i  in  1  synchronous clear of counters and return to IDLE.
- snap_req_i  in  1  single-cycle request to capture a snapshot.
- snap_valid_o  out  1  snapshot held and valid.
- snap_ready_i  in  1  consumer accepts the snapshot.
- snap_cycle_o  out  CNT_W  captured cycle count.
- snap_stall_o  out  CNT_W  captured stall count.
- snap_flush_o  out  CNT_W  captured flush count.
- snap_pc_o  out  32  captured PC.
- cycle_cnt_o  out  CNT_W  live cycle count.
- stall_cnt_o  out  CNT_W  live stall count.
- flush_cnt_o  out  CNT_W  live flush count.
- halt_o  out  1  halt request, sticky.
- state_o  out  2  FSM state: IDLE=0, RUN=1, HALT=2.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All counters 0; state IDLE.
  - halt_o=0, snap_valid_o=0, all snapshot fields 0.
- IDLE:
  - No counting.
  - Transition to RUN on the first rising edge that samples start_i=1. That same edge counts as cycle 0, with no increment.
- RUN, on each edge with start_i=1:
  - cycle_cnt increments by 1.
  - stall_cnt increments if stall_i=1.
  - flush_cnt increments if flush_i=1.
  - stall_i and flush_i are independent; both high increments both counters.
- RUN, on an edge with start_i=0: all counters hold (pause). State stays RUN.
- Halt condition:
  - When cycle_cnt reaches MAX_CYCLES-1 and an increment occurs, go to HALT on that edge.
  - halt_o=1 is registered on the same edge, i.e. visible one cycle after the final counted cycle.
  - Counters freeze in HALT.
  - The increment that reaches MAX_CYCLES still applies, so cycle_cnt_o=MAX_CYCLES in HALT.
  - Stall/flush inputs on that final edge are counted.
- HALT:
  - Left only via clear_i or reset.
  - start_i is ignored.
- Saturation: all counters saturate at all-ones (no wrap). This is relevant only when MAX_CYCLES exceeds 2^CNT_W.
- clear_i (any state):
  - Next edge: counters 0, state IDLE, halt_o=0.
  - Any pending snapshot is dropped (snap_valid_o=0).
  - clear_i has priority over counting and over snap_req_i.
- Snapshot:
  - If snap_req_i=1 and snap_valid_o=0, capture on that edge. Captured values are the post-update counter values and the pc_i sampled at that edge.
  - snap_valid_o=1 from the next cycle.
  - Fields hold stable while snap_valid_o=1.
  - The snapshot is released on the edge where snap_valid_o=1 and snap_ready_i=1, so snap_valid_o=0 the following cycle.
  - If snap_req_i arrives while snap_valid_o=1 and there is no handshake that cycle, it is ignored.
  - If snap_req_i coincides with the handshake edge, capture the new snapshot on that edge; snap_valid_o stays 1.
  - Snapshots are allowed in every state, including IDLE and HALT.
- Latency: live counters reflect an event one edge after it is sampled. Snapshot latency is 1 cycle.
- No combinational paths from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding constants ST_IDLE, ST_RUN, ST_HALT.
  - default CNT_W constant.
- One sub-module, sat_counter (CNT_W, enable, sync clear, saturate), instantiated three times.
- FSM and snapshot logic live in the top module.

Test Plan:
- Run to halt:
  - Stimulus: reset low for 10 ns, then high; start_i=1 at t=12.5 ns; stall_i/flush_i=0; MAX_CYCLES=20.
  - Response: cycle_cnt_o steps 0..20; halt_o=1 and state_o=2 after the edge counting cycle 20; counters frozen afterwards.
- Event counting:
  - Stimulus: stall_i high for 3 cycles, flush_i high for 2 cycles, one cycle with both high.
  - Response: stall_cnt_o=4, flush_cnt_o=3; cycle_cnt_o unaffected.
- Pause:
  - Stimulus: drop start_i for 5 cycles at cycle_cnt_o=7.
  - Response: all counters hold at their values; counting resumes from 7; halt occurs 5 cycles later than the no-pause run.
- Snapshot handshake:
  - Stimulus: snap_req_i pulse at cycle_cnt_o=9 with pc_i=0x24; snap_ready_i low for 3 cycles, then high.
  - Response: snap_cycle_o=10, snap_pc_o=36, held stable for 4 cycles; snap_valid_o drops after the handshake; a second request during hold is ignored.
- Clear and reset mid-run:
  - Stimulus: clear_i at cycle 5.
  - Response: counters 0, state IDLE, pending snapshot dropped.
  - Stimulus: assert rst_i=0 asynchronously mid-cycle in HALT.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
- Simultaneous events:
  - Stimulus: snap_req_i on the final counted edge.
  - Response: snapshot shows cycle=20 and halt_o=1 the next cycle.
  - Stimulus: clear_i together with snap_req_i.
  - Response: no snapshot is taken.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: monitor FSM encoding and counter width.
// Imported by the event monitor and its counters.
package cpu_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Enabled up-counter with synchronous clear that sticks at all-ones.
// Exposes its next value so callers can capture post-update counts.
module sat_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] q_nxt
);

  always_comb begin
    q_nxt = q;
    if (clr)
      q_nxt = '0;
    else if (en && (q != '1))
      q_nxt = q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else
      q <= q_nxt;
  end

endmodule

// File: rtl/pipeline_event_monitor.sv
// Run-control and perf monitor for the pipelined core: cycle budget,
// stall/flush counters and a valid/ready counter snapshot port.
module pipeline_event_monitor
  import cpu_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_CYCLES = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      pc_i,
  input  logic             clear_i,
  input  logic             snap_req_i,
  output logic             snap_valid_o,
  input  logic             snap_ready_i,
  output logic [CNT_W-1:0] snap_cycle_o,
  output logic [CNT_W-1:0] snap_stall_o,
  output logic [CNT_W-1:0] snap_flush_o,
  output logic [31:0]      snap_pc_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             halt_o,
  output logic [1:0]       state_o
);

  state_t           state;
  logic             cnt_en;
  logic             last;
  logic             snap_cap;
  logic             snap_rel;
  logic [CNT_W-1:0] cyc_nxt;
  logic [CNT_W-1:0] stl_nxt;
  logic [CNT_W-1:0] fls_nxt;

  assign cnt_en  = (state == ST_RUN) && start_i;
  assign last    = 64'(cycle_cnt_o) == 64'(MAX_CYCLES - 1);
  assign state_o = state;

  sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clr   (clear_i),
    .en    (cnt_en),
    .q     (cycle_cnt_o),
    .q_nxt (cyc_nxt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stl (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clr   (clear_i),
    .en    (cnt_en && stall_i),
    .q     (stall_cnt_o),
    .q_nxt (stl_nxt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fls (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clr   (clear_i),
    .en    (cnt_en && flush_i),
    .q     (flush_cnt_o),
    .q_nxt (fls_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      halt_o <= 1'b0;
    end else if (clear_i) begin
      state  <= ST_IDLE;
      halt_o <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_i)
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (start_i && last) begin
            state  <= ST_HALT;
            halt_o <= 1'b1;
          end
        end
        ST_HALT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A request on the release edge re-captures instead of releasing.
  assign snap_cap = !clear_i && snap_req_i
                    && (!snap_valid_o || snap_ready_i);
  assign snap_rel = !clear_i && !snap_cap
                    && snap_valid_o && snap_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      snap_valid_o <= 1'b0;
      snap_cycle_o <= '0;
      snap_stall_o <= '0;
      snap_flush_o <= '0;
      snap_pc_o    <= '0;
    end else begin
      unique case (1'b1)
        clear_i: snap_valid_o <= 1'b0;
        snap_cap: begin
          snap_valid_o <= 1'b1;
          snap_cycle_o <= cyc_nxt;
          snap_stall_o <= stl_nxt;
          snap_flush_o <= fls_nxt;
          snap_pc_o    <= pc_i;
        end
        snap_rel: snap_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
